// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
package dmem_lsu_pkg;

  // Access size encoding, shared by req_size and the SIZE bus output
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Bus cycles without acknowledge before the access is abandoned
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } lsu_state_e;

  // Halfwords need even addresses, words need 4-byte aligned addresses
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lsu_ext.sv
// Load data formatter: picks the low byte/half of the bus word and extends it.
module lsu_ext
  import dmem_lsu_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic [BIT_WIDTH-1:0] raw,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  output logic [BIT_WIDTH-1:0] data
);

  // Sub-word loads are right-aligned on the bus; fill upper bits with sign or zero
  always_comb begin
    data = raw;
    case (size)
      SZ_HALF: data = {{(BIT_WIDTH-16){sign_ext & raw[15]}}, raw[15:0]};
      SZ_BYTE: data = {{(BIT_WIDTH-8){sign_ext & raw[7]}}, raw[7:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: one outstanding bus access, ack or timeout ends it.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n,
  inout  wire  [BIT_WIDTH-1:0] DDT
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e           state, state_nxt;
  logic [CW-1:0]        wait_cnt;
  logic                 sign_q;
  logic [BIT_WIDTH-1:0] wdata_q;
  logic [BIT_WIDTH-1:0] wdata_fmt;
  logic [BIT_WIDTH-1:0] ext_data;
  logic                 misal;
  logic                 accept;
  logic                 ack;
  logic                 tmo;
  logic                 drive_en;

  assign misal  = is_misaligned(req_size, req_addr[1:0]);
  assign accept = req_valid && req_ready;
  assign ack    = (state == ST_BUS) && !ACKD_n;
  // Last unacknowledged cycle: counter would reach TIMEOUT on this edge
  assign tmo    = (state == ST_BUS) && ACKD_n && (wait_cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next state: misaligned requests are answered from IDLE without a bus cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid && !misal) state_nxt = ST_BUS;
      ST_BUS:  if (ack || tmo)          state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and bus registers
  always_comb begin
    req_ready = (state == ST_IDLE);
    drive_en  = MREQ && WRITE;
  end

  // Store data is right-aligned with unused upper lanes forced to zero
  always_comb begin
    wdata_fmt = req_wdata;
    case (req_size)
      SZ_HALF: wdata_fmt = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
      SZ_BYTE: wdata_fmt = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
      default: wdata_fmt = req_wdata;
    endcase
  end

  assign DDT = drive_en ? wdata_q : {BIT_WIDTH{1'bz}};

  lsu_ext #(.BIT_WIDTH(BIT_WIDTH)) u_ext (
    .raw      (DDT),
    .size     (SIZE),
    .sign_ext (sign_q),
    .data     (ext_data)
  );

  // Bus cycle registers and the single-cycle response pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MREQ       <= 1'b0;
      WRITE      <= 1'b0;
      SIZE       <= SZ_WORD;
      DAD        <= '0;
      sign_q     <= 1'b0;
      wdata_q    <= '0;
      wait_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      if (accept) begin
        if (misal) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end else begin
          MREQ     <= 1'b1;
          WRITE    <= req_write;
          SIZE     <= req_size;
          DAD      <= req_addr;
          sign_q   <= req_signed;
          wdata_q  <= wdata_fmt;
          wait_cnt <= '0;
        end
      end else if (state == ST_BUS) begin
        if (ack) begin
          MREQ       <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= WRITE ? '0 : ext_data;
        end else if (tmo) begin
          MREQ       <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu with a transaction-level reference model.
module tb_dmem_lsu;
  localparam int BW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid, req_ready, req_write, req_signed;
  logic [1:0]    req_size;
  logic [BW-1:0] req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [BW-1:0] resp_rdata, DAD;
  logic          MREQ, WRITE, ACKD_n;
  logic [1:0]    SIZE;
  wire  [BW-1:0] DDT;
  logic [BW-1:0] bus_drv;

  // Memory side drives the data bus whenever the LSU is not storing
  assign DDT = (MREQ && WRITE) ? {BW{1'bz}} : bus_drv;

  always #5 clk = ~clk;

  dmem_lsu #(.BIT_WIDTH(BW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
    .ACKD_n(ACKD_n), .DDT(DDT)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Loaded value as the pipeline should see it
  function automatic logic [BW-1:0] ref_load(input logic [BW-1:0] d, input logic [1:0] sz, input logic sg);
    longint v;
    case (sz)
      2'b01: begin v = longint'(d % 65536); if (sg && v >= 32768) v -= 65536; end
      2'b10: begin v = longint'(d % 256);   if (sg && v >= 128)   v -= 256;   end
      default: v = longint'(d);
    endcase
    return v[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] ref_store(input logic [BW-1:0] w, input logic [1:0] sz);
    case (sz)
      2'b01:   return w % 65536;
      2'b10:   return w % 256;
      default: return w;
    endcase
  endfunction

  function automatic logic ref_misal(input logic [1:0] sz, input logic [BW-1:0] a);
    return (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b00 && (a % 4) != 0);
  endfunction

  // One transaction; called at a negedge, returns at the negedge of the response cycle
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [BW-1:0] addr, input logic [BW-1:0] wd,
                        input int ack_dly, input logic [BW-1:0] mem);
    int n;
    bit got;
    bit tmo_exp;
    chk("ready", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    // Scramble request fields; they must not reach the bus
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom_range(0, 2));
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (ref_misal(sz, addr)) begin
      @(negedge clk);
      chk("mis_valid", resp_valid, 1);
      chk("mis_err", resp_err, 1);
      chk("mis_mreq", MREQ, 0);
      return;
    end
    bus_drv = w ? '0 : mem;
    tmo_exp = (ack_dly >= TMO);
    n = 0; got = 0;
    while (n < TMO + 4) begin
      @(negedge clk);
      if (resp_valid) begin got = 1; break; end
      chk("mreq", MREQ, 1);
      chk("dad", DAD, addr);
      chk("write", WRITE, w);
      chk("size", SIZE, sz);
      if (w) chk("ddt_st", DDT, ref_store(wd, sz));
      ACKD_n = (n == ack_dly) ? 1'b0 : 1'b1;
      n++;
    end
    ACKD_n = 1'b1;
    chk("resp_seen", got, 1);
    chk("lat", n, tmo_exp ? TMO : ack_dly + 1);
    chk("mreq_off", MREQ, 0);
    chk("err", resp_err, tmo_exp);
    if (!tmo_exp) chk("rdata", resp_rdata, w ? '0 : ref_load(mem, sz, sg));
    bus_drv = '0;
    if (w) chk("ddt_free", DDT, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ACKD_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; bus_drv = '0;
    repeat (3) @(negedge clk);
    chk("rst_mreq", MREQ, 0);
    chk("rst_write", WRITE, 0);
    chk("rst_size", SIZE, 0);
    chk("rst_dad", DAD, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_rd", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_ddt", DDT, 0);
    chk("rst_ready", req_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    do_req(0, 2'b00, 0, 32'h0800_0000, 0, 0, 32'h1234_5678);
    do_req(0, 2'b10, 1, 32'h0800_0001, 0, 1, 32'hABCD_EF80);
    do_req(0, 2'b10, 0, 32'h0800_0002, 0, 0, 32'hABCD_EF80);
    do_req(0, 2'b01, 1, 32'h0800_0002, 0, 0, 32'h5555_8001);
    do_req(1, 2'b10, 0, 32'hF000_0000, 32'h1234_5641, 2, 32'h0);
    do_req(0, 2'b01, 0, 32'h0800_0003, 0, 0, 32'h0);
    do_req(0, 2'b00, 0, 32'h0800_0002, 0, 0, 32'h0);
    do_req(0, 2'b00, 0, 32'h0800_0010, 0, TMO + 5, 32'hDEAD_BEEF);
    do_req(0, 2'b00, 0, 32'h0800_0020, 0, 3, 32'hCAFE_F00D);
    do_req(0, 2'b01, 0, 32'h0800_0024, 0, TMO - 1, 32'h0000_F00D);

    // Acknowledge while idle must not produce a response
    ACKD_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack_rv", resp_valid, 0);
      chk("idle_ack_mreq", MREQ, 0);
    end
    ACKD_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a bus cycle aborts silently
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0800_0040;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_mreq_on", MREQ, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_mreq_off", MREQ, 0);
    chk("mid_rv", resp_valid, 0);
    chk("mid_dad", DAD, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_rv", resp_valid, 0);
    end
    do_req(0, 2'b00, 0, 32'h0800_0044, 0, 1, 32'h8765_4321);

    // Random traffic, back-to-back or with short idle gaps
    repeat (120) begin
      int r;
      int dly;
      r   = int'($urandom_range(0, 9));
      dly = (r == 9) ? TMO + 2 : (r == 8) ? TMO - 1 : r % 4;
      do_req(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), $urandom,
             $urandom, dly, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter BIT_WIDTH, default 32: data bus and address width.
REQ-002 Parameter TIMEOUT, default 16: maximum number of MREQ cycles without acknowledge before abort.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  pipeline memory request present.
REQ-006 req_ready  output  1  LSU accepts a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 word, 01 halfword, 10 byte.
REQ-009 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_addr  input  BIT_WIDTH  byte address.
REQ-011 req_wdata  input  BIT_WIDTH  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  BIT_WIDTH  extended load data, valid with resp_valid.
REQ-014 resp_err  output  1  misaligned or timeout, valid with resp_valid.
REQ-015 DAD  output  BIT_WIDTH  data bus address.
REQ-016 MREQ  output  1  bus request, active-high.
REQ-017 WRITE  output  1  1 = store cycle.
REQ-018 SIZE  output  2  same encoding as req_size.
REQ-019 ACKD_n  input  1  bus acknowledge, active-low.
REQ-020 DDT  inout  BIT_WIDTH  data bus; driven only while MREQ&&WRITE, else high-Z.

Function
REQ-021 States: IDLE, BUS; req_ready = (state==IDLE).
REQ-022 Acceptance on an edge with req_valid&&req_ready latches addr, size, write, signed, and wdata.
REQ-023 Misaligned requests (half with addr[0]=1; word with addr[1:0]!=0) stay in IDLE, issue no bus cycle, and give resp_valid=1 and resp_err=1 in the next cycle.
REQ-024 Aligned acceptance enters BUS; MREQ, WRITE, SIZE, and DAD are registered and valid from the cycle following acceptance.
REQ-025 Stores: DDT carries the latched wdata (byte in [7:0], half in [15:0], upper bits zero).
REQ-026 In BUS, ACKD_n is sampled each rising edge; ACKD_n=0 causes a return to IDLE, MREQ=0, and resp_valid=1 with resp_err=0 in the following cycle.
REQ-027 Loads capture DDT at the ack edge; the byte comes from [7:0] and the half from [15:0]; extension follows the latched req_signed.
REQ-028 Store responses carry resp_rdata=0.
REQ-029 A wait counter increments per BUS cycle without ack; on reaching TIMEOUT the block returns to IDLE, drops MREQ, and responds with resp_err=1.
REQ-030 Minimum latency is 2 edges (accept edge N, ack edge N+1, resp_valid in cycle after N+1); back-to-back acceptance is allowed in the resp_valid cycle.
REQ-031 DAD, SIZE, WRITE, and DDT are held stable for the whole BUS phase; req_* changes are ignored outside acceptance.
REQ-032 ACKD_n low while IDLE is ignored.

Reset
REQ-033 rst low forces asynchronously: IDLE, MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT high-Z, resp_valid=0, resp_rdata=0, resp_err=0, wait counter 0.
REQ-034 Reset during BUS aborts without any response; the first request after rst rises is accepted normally.

Structure
REQ-035 A shared package holds the SIZE encodings, the state encoding, and the default TIMEOUT.
REQ-036 Load alignment/extension is one combinational sub-module, lsu_ext (inputs: raw data, size, signed; output: extended data).

Verification
REQ-037 Load word at 0x0800_0000, memory 0x1234_5678, ack in first MREQ cycle -> resp_rdata=0x1234_5678 two edges after acceptance, resp_err=0.
REQ-038 Signed byte load, DDT[7:0]=0x80 -> resp_rdata=0xFFFF_FF80; unsigned -> 0x0000_0080; signed half 0x8001 -> 0xFFFF_8001.
REQ-039 Store byte 0x41 to 0xF000_0000 -> MREQ=1, WRITE=1, SIZE=10, DDT=0x0000_0041 until ack; DDT high-Z afterwards.
REQ-040 Half load at 0x0800_0003 -> no MREQ, resp_err=1 in the next cycle.
REQ-041 ACKD_n held high -> MREQ drops after 16 cycles, resp_err=1; ack delayed 3 cycles -> normal response with DAD stable throughout.
REQ-042 rst pulsed low mid-BUS -> MREQ=0 immediately, no resp_valid; next load completes normally.
